// File: rtl/desc_queue_pkg.sv
// Shared types, default widths and the priority picker for desc_queue_mgr.
package desc_queue_pkg;

  localparam int DQ_NUM_PORTS = 16;
  localparam int DQ_NUM_PRIO  = 8;
  localparam int DQ_DEPTH     = 8;
  localparam int DQ_ADDR_W    = 12;
  localparam int DQ_LEN_W     = 8;
  localparam int DQ_DESC_W    = DQ_ADDR_W + DQ_LEN_W;
  localparam int SEL_W        = 32;  // widest priority mask prio_sel accepts

  typedef struct packed {
    logic [DQ_ADDR_W-1:0] addr;
    logic [DQ_LEN_W-1:0]  len;
  } desc_t;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } prio_sel_t;

  // Lowest set bit wins: priority 0 is the most urgent.
  function automatic prio_sel_t prio_sel(input logic [SEL_W-1:0] mask);
    prio_sel_t r;
    r = '0;
    for (int i = SEL_W - 1; i >= 0; i--) begin
      if (mask[i]) begin
        r.found = 1'b1;
        r.idx   = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/desc_fifo.sv
// One circular descriptor queue: pointers, occupancy count, storage and
// registered full/almost_full flags derived from the post-update count.
module desc_fifo #(
  parameter int DEPTH    = 8,
  parameter int DW       = 20,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          almost_full,
  output logic          empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_AF   = (PTR_W + 1)'(AFULL_TH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nxt;
  logic [DW-1:0]    mem [DEPTH];
  logic             do_wr, do_rd;

  // Both guards use the pre-update count, so a full queue drops a write
  // even when it is being read in the same cycle.
  assign do_wr   = wr_en && (count != CNT_FULL);
  assign do_rd   = rd_en && (count != '0);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_wr && !do_rd)      count_nxt = count + 1'b1;
    else if (!do_wr && do_rd) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      full        <= (count_nxt == CNT_FULL);
      almost_full <= (count_nxt >= CNT_AF);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/desc_queue_mgr.sv
// Per-(port, priority) descriptor queues with a strict-priority dequeue per port.
// Optional DESC_QUEUE_DROP_CNT_EN adds per-port saturating drop counters (drop_cnt).
module desc_queue_mgr
  import desc_queue_pkg::*;
#(
  parameter int NUM_PORTS = DQ_NUM_PORTS,
  parameter int NUM_PRIO  = DQ_NUM_PRIO,
  parameter int DEPTH     = DQ_DEPTH,
  parameter int ADDR_W    = DQ_ADDR_W,
  parameter int LEN_W     = DQ_LEN_W,
  parameter int AFULL_TH  = DEPTH - 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enq_vld,
  input  logic [$clog2(NUM_PORTS)-1:0]          enq_port,
  input  logic [$clog2(NUM_PRIO)-1:0]           enq_prio,
  input  logic [ADDR_W-1:0]                     enq_addr,
  input  logic [LEN_W-1:0]                      enq_len,
  output logic                                  enq_drop,
  input  logic [NUM_PORTS-1:0]                  deq_req,
  input  logic [NUM_PORTS*NUM_PRIO-1:0]         ready,
  output logic [NUM_PORTS-1:0]                  deq_vld,
  output logic [NUM_PORTS*ADDR_W-1:0]           deq_addr,
  output logic [NUM_PORTS*LEN_W-1:0]            deq_len,
  output logic [NUM_PORTS*$clog2(NUM_PRIO)-1:0] deq_prio,
  output logic [NUM_PORTS*NUM_PRIO-1:0]         full,
  output logic [NUM_PORTS*NUM_PRIO-1:0]         almost_full
`ifdef DESC_QUEUE_DROP_CNT_EN
  ,
  output logic [NUM_PORTS*16-1:0]               drop_cnt
`endif
);

  localparam int NQ     = NUM_PORTS * NUM_PRIO;
  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int PRIO_W = $clog2(NUM_PRIO);
  localparam int DW     = ADDR_W + LEN_W;

  logic [NQ-1:0]        q_hit, q_rd, q_empty;
  logic [DW-1:0]        q_data [NQ];
  logic [NUM_PORTS-1:0] serve, port_drop;
  logic [PRIO_W-1:0]    sel_idx  [NUM_PORTS];
  logic [DW-1:0]        sel_data [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    for (genvar q = 0; q < NUM_PRIO; q++) begin : g_prio
      assign q_hit[p*NUM_PRIO+q] = enq_vld && (enq_port == PORT_W'(p)) &&
                                   (enq_prio == PRIO_W'(q));
      desc_fifo #(.DEPTH(DEPTH), .DW(DW), .AFULL_TH(AFULL_TH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (q_hit[p*NUM_PRIO+q]),
        .wr_data     ({enq_addr, enq_len}),
        .rd_en       (q_rd[p*NUM_PRIO+q]),
        .rd_data     (q_data[p*NUM_PRIO+q]),
        .full        (full[p*NUM_PRIO+q]),
        .almost_full (almost_full[p*NUM_PRIO+q]),
        .empty       (q_empty[p*NUM_PRIO+q])
      );
    end
    assign port_drop[p] = |(q_hit[p*NUM_PRIO +: NUM_PRIO] & full[p*NUM_PRIO +: NUM_PRIO]);
  end

  // Dequeue handshake: deq_req[p] is a one-cycle request with no retry memory;
  // deq_vld[p] pulses for exactly one cycle after a request that found an
  // eligible queue (non-empty before this edge and ready bit set).
  always_comb begin
    logic [NUM_PRIO-1:0] elig;
    prio_sel_t           sel;
    q_rd = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      elig        = ~q_empty[p*NUM_PRIO +: NUM_PRIO] & ready[p*NUM_PRIO +: NUM_PRIO];
      sel         = prio_sel(SEL_W'(elig));
      serve[p]    = deq_req[p] && sel.found;
      sel_idx[p]  = sel.idx[PRIO_W-1:0];
      sel_data[p] = '0;
      for (int q = 0; q < NUM_PRIO; q++) begin
        if (sel_idx[p] == PRIO_W'(q)) begin
          q_rd[p*NUM_PRIO+q] = serve[p];
          sel_data[p]        = q_data[p*NUM_PRIO+q];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enq_drop <= 1'b0;
      deq_vld  <= '0;
      deq_addr <= '0;
      deq_len  <= '0;
      deq_prio <= '0;
    end else begin
      enq_drop <= |port_drop;
      deq_vld  <= serve;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (serve[p]) begin
          deq_addr[p*ADDR_W +: ADDR_W] <= sel_data[p][DW-1:LEN_W];
          deq_len[p*LEN_W +: LEN_W]    <= sel_data[p][LEN_W-1:0];
          deq_prio[p*PRIO_W +: PRIO_W] <= sel_idx[p];
        end
      end
    end
  end

`ifdef DESC_QUEUE_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_drop[p] && (drop_cnt[p*16 +: 16] != 16'hFFFF))
          drop_cnt[p*16 +: 16] <= drop_cnt[p*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_desc_queue_mgr.sv
// Bench for desc_queue_mgr: directed scenarios plus random traffic against a
// queue-based reference model; drop_cnt is checked when DESC_QUEUE_DROP_CNT_EN is set.
module tb_desc_queue_mgr;

  localparam int NUM_PORTS = 16;
  localparam int NUM_PRIO  = 8;
  localparam int DEPTH     = 8;
  localparam int ADDR_W    = 12;
  localparam int LEN_W     = 8;
  localparam int AFULL_TH  = DEPTH - 2;
  localparam int NQ        = NUM_PORTS * NUM_PRIO;
  localparam int PORT_W    = 4;
  localparam int PRIO_W    = 3;
  localparam int DW        = ADDR_W + LEN_W;

  logic                        clk, rst;
  logic                        enq_vld;
  logic [PORT_W-1:0]           enq_port;
  logic [PRIO_W-1:0]           enq_prio;
  logic [ADDR_W-1:0]           enq_addr;
  logic [LEN_W-1:0]            enq_len;
  logic                        enq_drop;
  logic [NUM_PORTS-1:0]        deq_req;
  logic [NQ-1:0]               ready;
  logic [NUM_PORTS-1:0]        deq_vld;
  logic [NUM_PORTS*ADDR_W-1:0] deq_addr;
  logic [NUM_PORTS*LEN_W-1:0]  deq_len;
  logic [NUM_PORTS*PRIO_W-1:0] deq_prio;
  logic [NQ-1:0]               full, almost_full;
`ifdef DESC_QUEUE_DROP_CNT_EN
  logic [NUM_PORTS*16-1:0]     drop_cnt;
`endif

  desc_queue_mgr #(
    .NUM_PORTS(NUM_PORTS), .NUM_PRIO(NUM_PRIO), .DEPTH(DEPTH),
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .AFULL_TH(AFULL_TH)
  ) dut (
    .clk(clk), .rst(rst),
    .enq_vld(enq_vld), .enq_port(enq_port), .enq_prio(enq_prio),
    .enq_addr(enq_addr), .enq_len(enq_len), .enq_drop(enq_drop),
    .deq_req(deq_req), .ready(ready),
    .deq_vld(deq_vld), .deq_addr(deq_addr), .deq_len(deq_len), .deq_prio(deq_prio),
    .full(full), .almost_full(almost_full)
`ifdef DESC_QUEUE_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0]     exp_q [NQ][$];
  logic [ADDR_W-1:0] m_addr [NUM_PORTS];
  logic [LEN_W-1:0]  m_len  [NUM_PORTS];
  logic [PRIO_W-1:0] m_prio [NUM_PORTS];
  logic [15:0]       m_drop [NUM_PORTS];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NQ; i++) exp_q[i].delete();
    for (int p = 0; p < NUM_PORTS; p++) begin
      m_addr[p] = '0;
      m_len[p]  = '0;
      m_prio[p] = '0;
      m_drop[p] = '0;
    end
  endtask

  // One clock: predict from the model, advance the DUT, compare, commit.
  task automatic cycle();
    logic [NUM_PORTS-1:0]        e_vld;
    logic                        e_drop;
    logic [NQ-1:0]               e_full, e_af;
    logic [NUM_PORTS*ADDR_W-1:0] e_addr;
    logic [NUM_PORTS*LEN_W-1:0]  e_len;
    logic [NUM_PORTS*PRIO_W-1:0] e_prio;
    logic [NUM_PORTS*16-1:0]     e_dcnt;
    logic [DW-1:0]               d;
    logic                        found;
    int                          ei;
    e_vld  = '0;
    ei     = int'(enq_port) * NUM_PRIO + int'(enq_prio);
    e_drop = enq_vld && (exp_q[ei].size() == DEPTH);
    for (int p = 0; p < NUM_PORTS; p++) begin
      found = 1'b0;
      for (int q = 0; q < NUM_PRIO; q++) begin
        if (!found && deq_req[p] && ready[p*NUM_PRIO+q] && exp_q[p*NUM_PRIO+q].size() > 0) begin
          found     = 1'b1;
          d         = exp_q[p*NUM_PRIO+q].pop_front();
          m_addr[p] = d[DW-1:LEN_W];
          m_len[p]  = d[LEN_W-1:0];
          m_prio[p] = PRIO_W'(q);
          e_vld[p]  = 1'b1;
        end
      end
    end
    if (enq_vld && !e_drop) exp_q[ei].push_back({enq_addr, enq_len});
    if (e_drop && m_drop[enq_port] != 16'hFFFF) m_drop[enq_port] = m_drop[enq_port] + 16'd1;
    for (int i = 0; i < NQ; i++) begin
      e_full[i] = (exp_q[i].size() == DEPTH);
      e_af[i]   = (exp_q[i].size() >= AFULL_TH);
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      e_addr[p*ADDR_W +: ADDR_W] = m_addr[p];
      e_len[p*LEN_W +: LEN_W]    = m_len[p];
      e_prio[p*PRIO_W +: PRIO_W] = m_prio[p];
      e_dcnt[p*16 +: 16]         = m_drop[p];
    end
    @(posedge clk);
    #1;
    check("deq_vld", deq_vld, e_vld);
    check("deq_addr", deq_addr, e_addr);
    check("deq_len", deq_len, e_len);
    check("deq_prio", deq_prio, e_prio);
    check("enq_drop", enq_drop, e_drop);
    check("full", full, e_full);
    check("almost_full", almost_full, e_af);
`ifdef DESC_QUEUE_DROP_CNT_EN
    check("drop_cnt", drop_cnt, e_dcnt);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    enq_vld  = 1'b0;
    enq_port = '0;
    enq_prio = '0;
    enq_addr = '0;
    enq_len  = '0;
    deq_req  = '0;
  endtask

  task automatic set_enq(input int port, input int prio, input int addr, input int len);
    enq_vld  = 1'b1;
    enq_port = PORT_W'(port);
    enq_prio = PRIO_W'(prio);
    enq_addr = ADDR_W'(addr);
    enq_len  = LEN_W'(len);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vld"}, deq_vld, '0);
    check({tag, "_addr"}, deq_addr, '0);
    check({tag, "_len"}, deq_len, '0);
    check({tag, "_prio"}, deq_prio, '0);
    check({tag, "_drop"}, enq_drop, '0);
    check({tag, "_full"}, full, '0);
    check({tag, "_afull"}, almost_full, '0);
`ifdef DESC_QUEUE_DROP_CNT_EN
    check({tag, "_dcnt"}, drop_cnt, '0);
`endif
  endtask

  task automatic random_phase(input int n);
    for (int k = 0; k < n; k++) begin
      enq_vld  = ($urandom_range(0, 9) < 7);
      enq_port = PORT_W'($urandom_range(0, 3));
      enq_prio = ($urandom_range(0, 1) == 0) ? PRIO_W'($urandom_range(0, 1))
                                             : PRIO_W'($urandom_range(0, 7));
      enq_addr = ADDR_W'($urandom);
      enq_len  = LEN_W'($urandom);
      deq_req  = NUM_PORTS'($urandom) & NUM_PORTS'($urandom);
      if ($urandom_range(0, 3) == 0) ready = {4{32'($urandom)}};
      else ready = '1;
      cycle();
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst   = 1'b1;
    ready = '1;
    idle();
    model_reset();
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single descriptor round trip
    set_enq(3, 5, 'h100, 64);
    cycle();
    idle();
    deq_req = 16'h0008;
    cycle();
    check("t1_vld", deq_vld, 16'h0008);
    check("t1_addr", deq_addr[3*ADDR_W +: ADDR_W], 12'h100);
    check("t1_len", deq_len[3*LEN_W +: LEN_W], 8'd64);
    check("t1_prio", deq_prio[3*PRIO_W +: PRIO_W], 3'd5);

    // ready mask gates strict priority
    idle();
    set_enq(2, 6, 'h260, 6);
    cycle();
    set_enq(2, 1, 'h210, 1);
    cycle();
    idle();
    ready[2*NUM_PRIO+1] = 1'b0;
    deq_req = 16'h0004;
    cycle();
    check("t2_prio_masked", deq_prio[2*PRIO_W +: PRIO_W], 3'd6);
    ready = '1;
    cycle();
    check("t2_prio_open", deq_prio[2*PRIO_W +: PRIO_W], 3'd1);
    check("t2_addr_open", deq_addr[2*ADDR_W +: ADDR_W], 12'h210);

    // fill, overflow, drain queue (0,0)
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(0, 0, 'h200 + i, i);
      cycle();
      if (i == AFULL_TH - 1) check("t3_afull_at_th", almost_full[0], 1'b1);
      if (i == AFULL_TH - 2) check("t3_afull_below", almost_full[0], 1'b0);
    end
    check("t3_full", full[0], 1'b1);
    set_enq(0, 0, 'hFFF, 255);
    cycle();
    check("t3_drop", enq_drop, 1'b1);
    idle();
    deq_req = 16'h0001;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      check("t3_order", deq_addr[ADDR_W-1:0], ADDR_W'('h200 + i));
    end
    check("t3_full_clear", full[0], 1'b0);

    // full queue with same-cycle enqueue and dequeue
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(1, 0, 'h300 + i, i);
      cycle();
    end
    set_enq(1, 0, 'h3FF, 99);
    deq_req = 16'h0002;
    cycle();
    check("t4_drop", enq_drop, 1'b1);
    check("t4_full", full[1*NUM_PRIO], 1'b0);
    check("t4_afull", almost_full[1*NUM_PRIO], 1'b1);
    check("t4_addr", deq_addr[1*ADDR_W +: ADDR_W], 12'h300);

    // wrap-around on queue (4,2)
    idle();
    for (int i = 0; i < 20; i++) begin
      set_enq(4, 2, 'h400 + i, i);
      deq_req = (i > 0) ? 16'h0010 : 16'h0000;
      cycle();
      if (i > 0) check("t5_wrap", deq_addr[4*ADDR_W +: ADDR_W], ADDR_W'('h400 + i - 1));
    end
    idle();
    deq_req = 16'h0010;
    cycle();
    check("t5_last", deq_addr[4*ADDR_W +: ADDR_W], 12'h413);

    // random traffic, then an asynchronous reset mid-stream
    random_phase(1500);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    idle();
    #2;
    rst = 1'b0;
    ready   = '1;
    deq_req = '1;
    cycle();
    check("post_rst_vld", deq_vld, '0);
    random_phase(1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
